// File: rtl/zanagotchi_if.sv
// Button inputs and pet status outputs of zanagotchi_core, bundled for the board top.
// The core uses the slave modport. The board or bench drives the buttons through the master modport.
interface zanagotchi_if #(
  parameter int W       = 8,
  parameter int IDADE_W = 16
);
  logic               b1;
  logic               b2;
  logic [2:0]         estado;
  logic [W-1:0]       fome;
  logic [W-1:0]       felicidade;
  logic [W-1:0]       sono;
  logic [IDADE_W-1:0] idade;
  logic               alerta;
  logic               morreu;

  modport master (
    output b1, b2,
    input  estado, fome, felicidade, sono, idade, alerta, morreu
  );

  modport slave (
    input  b1, b2,
    output estado, fome, felicidade, sono, idade, alerta, morreu
  );
endinterface

// File: rtl/zanagotchi_core.sv
// Pet core: mode FSM, three saturating attributes (fome, felicidade, sono), age counter,
// low-margin alert and rebirth out of MORTO. Buttons arrive synchronised and debounced.
module zanagotchi_core #(
  parameter int W          = 8,
  parameter int TICK_DIV   = 50_000_000,
  parameter int INC_FOME   = 1,
  parameter int INC_SONO   = 1,
  parameter int DEC_FEL    = 1,
  parameter int PASSO_ACAO = 4,
  parameter int INI_FOME   = 64,
  parameter int INI_FEL    = 192,
  parameter int INI_SONO   = 64,
  parameter int ALERTA     = 16,
  parameter int IDADE_W    = 16
) (
  input  logic          clk,
  input  logic          rst,
  zanagotchi_if.slave   bus
);

  typedef enum logic [2:0] {
    OCIOSO    = 3'd0,
    COMENDO   = 3'd1,
    BRINCANDO = 3'd2,
    DORMINDO  = 3'd3,
    MORTO     = 3'd4
  } estado_t;

  localparam int PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  localparam logic [W-1:0]     MAX_V     = '1;
  localparam logic [W:0]       STEP_FOME = (W+1)'(INC_FOME);
  localparam logic [W:0]       STEP_SONO = (W+1)'(INC_SONO);
  localparam logic [W:0]       STEP_FEL  = (W+1)'(DEC_FEL);
  localparam logic [W:0]       STEP_ACAO = (W+1)'(PASSO_ACAO);
  localparam logic [W-1:0]     RST_FOME  = W'(INI_FOME);
  localparam logic [W-1:0]     RST_FEL   = W'(INI_FEL);
  localparam logic [W-1:0]     RST_SONO  = W'(INI_SONO);
  localparam logic [W-1:0]     LIM_ALTO  = W'((2**W - 1) - ALERTA);
  localparam logic [W-1:0]     LIM_BAIXO = W'(ALERTA);
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICK_DIV - 1);

  // Arithmetic is done one bit wider so both the carry and the borrow can be seen and clamped.
  function automatic logic [W-1:0] sat_add(input logic [W-1:0] a, input logic [W:0] step);
    logic [W:0] s;
    s = {1'b0, a} + step;
    return (s > {1'b0, MAX_V}) ? MAX_V : s[W-1:0];
  endfunction

  function automatic logic [W-1:0] sat_sub(input logic [W-1:0] a, input logic [W:0] step);
    logic [W:0] s;
    s = {1'b0, a} - step;
    return s[W] ? '0 : s[W-1:0];
  endfunction

  estado_t            estado_q, estado_d;
  logic [W-1:0]       fome_q, fome_d;
  logic [W-1:0]       fel_q, fel_d;
  logic [W-1:0]       sono_q, sono_d;
  logic [IDADE_W-1:0] idade_q, idade_d;
  logic [PRE_W-1:0]   pre_q;
  logic               b1_q, b2_q;

  logic tick, e1, e2, death, rebirth;

  assign tick = (pre_q == PRE_LAST);
  assign e1   = bus.b1 & ~b1_q;
  assign e2   = bus.b2 & ~b2_q;

  // Next attribute values. The PRE-edge state selects the update rule.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    fome_d  = fome_q;
    fel_d   = fel_q;
    sono_d  = sono_q;
    idade_d = idade_q;
    if (tick && estado_q != MORTO) begin
      idade_d = (idade_q == '1) ? idade_q : idade_q + IDADE_W'(1);
      unique case (estado_q)
        OCIOSO: begin
          fome_d = sat_add(fome_q, STEP_FOME);
          sono_d = sat_add(sono_q, STEP_SONO);
          fel_d  = sat_sub(fel_q, STEP_FEL);
        end
        COMENDO: begin
          fome_d = sat_sub(fome_q, STEP_ACAO);
          sono_d = sat_add(sono_q, STEP_SONO);
          fel_d  = sat_sub(fel_q, STEP_FEL);
        end
        BRINCANDO: begin
          fel_d  = sat_add(fel_q, STEP_ACAO);
          fome_d = sat_add(fome_q, STEP_FOME);
          sono_d = sat_add(sono_q, STEP_SONO);
        end
        DORMINDO: begin
          sono_d = sat_sub(sono_q, STEP_ACAO);
          fome_d = sat_add(fome_q, STEP_FOME);
        end
        default: ;
      endcase
    end
  end

  assign death = (fome_d == MAX_V) || (sono_d == MAX_V) || (fel_d == '0);

  // Next state: death beats buttons, and buttons beat the auto-exit on goal.
  always_comb begin
    estado_d = estado_q;
    rebirth  = 1'b0;
    unique case (estado_q)
      OCIOSO: begin
        if (death)          estado_d = MORTO;
        else if (e1 && e2)  estado_d = DORMINDO;
        else if (e1)        estado_d = COMENDO;
        else if (e2)        estado_d = BRINCANDO;
      end
      COMENDO: begin
        if (death)                        estado_d = MORTO;
        else if (e1 || e2 || fome_d == '0) estado_d = OCIOSO;
      end
      BRINCANDO: begin
        if (death)                           estado_d = MORTO;
        else if (e1 || e2 || fel_d == MAX_V) estado_d = OCIOSO;
      end
      DORMINDO: begin
        if (death)                        estado_d = MORTO;
        else if (e1 || e2 || sono_d == '0) estado_d = OCIOSO;
      end
      MORTO: begin
        if (bus.b1 && bus.b2) begin
          rebirth  = 1'b1;
          estado_d = OCIOSO;
        end
      end
      default: estado_d = OCIOSO;
    endcase
  end

  // Rebirth restores the reset values but leaves the button edge detectors alone.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
    if (rst || rebirth) begin
      estado_q <= OCIOSO;
      fome_q   <= RST_FOME;
      fel_q    <= RST_FEL;
      sono_q   <= RST_SONO;
      idade_q  <= '0;
      pre_q    <= '0;
    end else begin
      estado_q <= estado_d;
      fome_q   <= fome_d;
      fel_q    <= fel_d;
      sono_q   <= sono_d;
      idade_q  <= idade_d;
      pre_q    <= tick ? '0 : pre_q + PRE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      b1_q <= 1'b0;
      b2_q <= 1'b0;
    end else begin
      b1_q <= bus.b1;
      b2_q <= bus.b2;
    end
  end

  assign bus.estado     = estado_q;
  assign bus.fome       = fome_q;
  assign bus.felicidade = fel_q;
  assign bus.sono       = sono_q;
  assign bus.idade      = idade_q;
  assign bus.morreu     = (estado_q == MORTO);
  assign bus.alerta     = (fome_q >= LIM_ALTO) || (sono_q >= LIM_ALTO) || (fel_q <= LIM_BAIXO);

endmodule

// File: tb/tb_zanagotchi_core.sv
// Directed self-checking bench for zanagotchi_core using a small configuration: W=4, TICK_DIV=4, ALERTA=2.
// Inputs are driven and outputs sampled on the falling edge. The core acts on the rising edge.
module tb_zanagotchi_core;

  logic clk = 1'b0;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  zanagotchi_if #(.W(4), .IDADE_W(16)) bus ();

  zanagotchi_core #(
    .W(4), .TICK_DIV(4), .INC_FOME(1), .INC_SONO(1), .DEC_FEL(1), .PASSO_ACAO(4),
    .INI_FOME(4), .INI_FEL(12), .INI_SONO(4), .ALERTA(2), .IDADE_W(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic clocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    bus.b1 = 1'b0;
    bus.b2 = 1'b0;
    clocks(1);
    rst    = 1'b0;
  endtask

  task automatic check_attr(input string tag, input int est, input int fo, input int fe,
                            input int so, input int id);
    check({tag, ".estado"}, 32'(bus.estado), est);
    check({tag, ".fome"},   32'(bus.fome), fo);
    check({tag, ".fel"},    32'(bus.felicidade), fe);
    check({tag, ".sono"},   32'(bus.sono), so);
    check({tag, ".idade"},  32'(bus.idade), id);
  endtask

  initial begin
    rst    = 1'b1;
    bus.b1 = 1'b0;
    bus.b2 = 1'b0;
    @(negedge clk);

    // 1: reset values, then three idle ticks.
    do_reset();
    check_attr("rst", 0, 4, 12, 4, 0);
    check("rst.alerta", 32'(bus.alerta), 0);
    check("rst.morreu", 32'(bus.morreu), 0);
    clocks(12);
    check_attr("idle3", 0, 7, 9, 7, 3);
    check("idle3.alerta", 32'(bus.alerta), 0);

    // 2: feed, then auto-exit when fome reaches 0 on the first tick.
    do_reset();
    bus.b1 = 1'b1;
    clocks(1);
    check("feed.enter", 32'(bus.estado), 1);
    bus.b1 = 1'b0;
    clocks(2);
    check_attr("feed.pre", 1, 4, 12, 4, 0);
    clocks(1);
    check_attr("feed.exit", 0, 0, 11, 5, 1);

    // 3: starvation; alert from tick 9, death at tick 11.
    do_reset();
    clocks(32);
    check("t8.alerta", 32'(bus.alerta), 0);
    clocks(4);
    check("t9.alerta", 32'(bus.alerta), 1);
    check("t9.fome", 32'(bus.fome), 13);
    clocks(4);
    check_attr("t10", 0, 14, 2, 14, 10);
    clocks(4);
    check_attr("t11.dead", 4, 15, 1, 15, 11);
    check("t11.morreu", 32'(bus.morreu), 1);

    // 4: frozen while dead with b1 only; both buttons give rebirth with a fresh prescaler.
    bus.b1 = 1'b1;
    clocks(40);
    check_attr("frozen", 4, 15, 1, 15, 11);
    bus.b2 = 1'b1;
    clocks(1);
    check_attr("reborn", 0, 4, 12, 4, 0);
    check("reborn.morreu", 32'(bus.morreu), 0);
    check("reborn.alerta", 32'(bus.alerta), 0);
    bus.b1 = 1'b0;
    bus.b2 = 1'b0;
    clocks(3);
    check("reborn.pre_tick", 32'(bus.fome), 4);
    clocks(1);
    check_attr("reborn.tick1", 0, 5, 11, 5, 1);

    // 5: both buttons rise on a tick cycle, then DORMINDO clamps sono at 0 and exits.
    do_reset();
    clocks(3);
    bus.b1 = 1'b1;
    bus.b2 = 1'b1;
    clocks(1);
    check_attr("tick_btn", 3, 5, 11, 5, 1);
    bus.b1 = 1'b0;
    bus.b2 = 1'b0;
    clocks(4);
    check_attr("sleep1", 3, 6, 11, 1, 2);
    clocks(4);
    check_attr("sleep.clamp", 0, 7, 11, 0, 3);

    // 6: reset asserted mid-prescaler while DORMINDO.
    do_reset();
    bus.b1 = 1'b1;
    bus.b2 = 1'b1;
    clocks(1);
    check("rst6.sleep", 32'(bus.estado), 3);
    bus.b1 = 1'b0;
    bus.b2 = 1'b0;
    clocks(1);
    do_reset();
    check_attr("rst6.after", 0, 4, 12, 4, 0);
    clocks(3);
    check("rst6.pre_tick", 32'(bus.fome), 4);
    clocks(1);
    check_attr("rst6.tick1", 0, 5, 11, 5, 1);

    // 7: play clamps felicidade at MAX and exits; a button press leaves COMENDO.
    do_reset();
    bus.b2 = 1'b1;
    clocks(1);
    check("play.enter", 32'(bus.estado), 2);
    bus.b2 = 1'b0;
    clocks(3);
    check_attr("play.clamp", 0, 5, 15, 5, 1);
    bus.b1 = 1'b1;
    clocks(1);
    check("btn.comendo", 32'(bus.estado), 1);
    bus.b1 = 1'b0;
    bus.b2 = 1'b1;
    clocks(1);
    check("btn.exit", 32'(bus.estado), 0);
    check("btn.fome", 32'(bus.fome), 5);
    bus.b2 = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
